// File: rtl/maze_path_player.sv
// Move stack for the maze solver's DFS search, replayed oldest-first over valid/ready.
// Tracks the rat's 4-bit x/y position while replaying; done/fail are sticky until clr.
module maze_path_player #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic [1:0]    push_val_i,
    input  logic          pop_i,
    output logic [1:0]    pop_val_o,
    output logic          empty_o,
    output logic          full_o,
    input  logic          solved_i,
    input  logic          run_i,
    output logic          move_valid_o,
    input  logic          move_ready_i,
    output logic [1:0]    move_o,
    output logic [3:0]    x_o,
    output logic [3:0]    y_o,
    output logic          done_o,
    output logic          fail_o
);

    typedef enum logic [2:0] {StIdle, StReady, StReplay, StDone, StErr} state_e;

    localparam logic [AW:0]   SpOne  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   SpFull = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] RdOne  = {{(AW - 1){1'b0}}, 1'b1};

    state_e        state_q;
    logic [AW:0]   sp_q;
    logic [AW-1:0] rd_q;
    logic [3:0]    x_q, y_q;
    logic          done_q, fail_q;
    logic [1:0]    mem_q [DEPTH];

    logic [AW:0]   top_idx;
    logic          stack_err;
    logic          wr_en;
    logic [AW-1:0] wr_addr;

    assign top_idx      = sp_q - SpOne;
    assign empty_o      = (sp_q == '0);
    assign full_o       = (sp_q == SpFull);
    assign pop_val_o    = empty_o ? 2'b00 : mem_q[top_idx[AW-1:0]];
    assign move_valid_o = (state_q == StReplay);
    assign move_o       = move_valid_o ? mem_q[rd_q] : 2'b00;
    assign x_o          = x_q;
    assign y_o          = y_q;
    assign done_o       = done_q;
    assign fail_o       = fail_q;

    // A push+pop pair on an empty stack still counts as underflow.
    assign stack_err = (pop_i && empty_o) || (push_i && !pop_i && full_o);
    assign wr_en     = (state_q == StIdle) && !clr_i && push_i && !stack_err;
    assign wr_addr   = pop_i ? top_idx[AW-1:0] : sp_q[AW-1:0];

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_addr] <= push_val_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            sp_q    <= '0;
            rd_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else if (clr_i) begin
            state_q <= StIdle;
            sp_q    <= '0;
            rd_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (stack_err) begin
                        state_q <= StErr;
                        fail_q  <= 1'b1;
                    end else begin
                        if (push_i && !pop_i) begin
                            sp_q <= sp_q + SpOne;
                        end else if (pop_i && !push_i) begin
                            sp_q <= top_idx;
                        end
                        if (solved_i) begin
                            state_q <= StReady;
                        end
                    end
                end
                StReady: begin
                    if (run_i) begin
                        if (empty_o) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            rd_q    <= '0;
                            x_q     <= '0;
                            y_q     <= '0;
                            state_q <= StReplay;
                        end
                    end
                end
                StReplay: begin
                    if (move_ready_i) begin
                        unique case (move_o)
                            2'b00:   y_q <= y_q - 4'd1;
                            2'b01:   x_q <= x_q + 4'd1;
                            2'b10:   x_q <= x_q - 4'd1;
                            default: y_q <= y_q + 4'd1;
                        endcase
                        rd_q <= rd_q + RdOne;
                        if ({1'b0, rd_q} == top_idx) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_path_player.sv
// Bench for maze_path_player: directed table, hand sequences, and random traffic
// checked against a queue-based model of the path recorder.
module tb_maze_path_player;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    localparam int MIdle   = 0;
    localparam int MReady  = 1;
    localparam int MReplay = 2;
    localparam int MDone   = 3;
    localparam int MErr    = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr, push, pop, solved, run, move_ready;
    logic [1:0] push_val;
    logic [1:0] pop_val, move;
    logic       empty, full, move_valid, done, fail;
    logic [3:0] x, y;

    int errors = 0;
    int checks = 0;

    maze_path_player #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clr_i       (clr),
        .push_i      (push),
        .push_val_i  (push_val),
        .pop_i       (pop),
        .pop_val_o   (pop_val),
        .empty_o     (empty),
        .full_o      (full),
        .solved_i    (solved),
        .run_i       (run),
        .move_valid_o(move_valid),
        .move_ready_i(move_ready),
        .move_o      (move),
        .x_o         (x),
        .y_o         (y),
        .done_o      (done),
        .fail_o      (fail)
    );

    always #5 clk = ~clk;

    logic [16:0] dut_vec;
    assign dut_vec = {empty, full, pop_val, move_valid, move, x, y, done, fail};

    // Reference model: the stack is a queue, replay walks it by index.
    logic [1:0] m_stk[$];
    int         m_mode, m_rd, m_x, m_y;
    logic       m_done, m_fail;
    logic [1:0] acc[$];

    task automatic model_reset();
        m_stk.delete();
        m_mode = MIdle; m_rd = 0; m_x = 0; m_y = 0; m_done = 1'b0; m_fail = 1'b0;
    endtask

    task automatic model_step(input logic pu, po, input logic [1:0] v,
                              input logic so, ru, rdy, cl);
        if (cl) begin
            model_reset();
        end else begin
            case (m_mode)
                MIdle: begin
                    if ((po && m_stk.size() == 0) || (pu && !po && m_stk.size() == DEPTH)) begin
                        m_mode = MErr; m_fail = 1'b1;
                    end else begin
                        if (pu && po) m_stk[m_stk.size() - 1] = v;
                        else if (pu) m_stk.push_back(v);
                        else if (po) void'(m_stk.pop_back());
                        if (so) m_mode = MReady;
                    end
                end
                MReady: if (ru) begin
                    if (m_stk.size() == 0) begin
                        m_mode = MDone; m_done = 1'b1;
                    end else begin
                        m_rd = 0; m_x = 0; m_y = 0; m_mode = MReplay;
                    end
                end
                MReplay: if (rdy) begin
                    case (m_stk[m_rd])
                        2'd0: m_y = (m_y + 15) % 16;
                        2'd1: m_x = (m_x + 1) % 16;
                        2'd2: m_x = (m_x + 15) % 16;
                        default: m_y = (m_y + 1) % 16;
                    endcase
                    m_rd++;
                    if (m_rd == m_stk.size()) begin
                        m_mode = MDone; m_done = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [16:0] model_out();
        logic       e, f, mv;
        logic [1:0] pv, mm;
        logic [3:0] xx, yy;
        e  = (m_stk.size() == 0);
        f  = (m_stk.size() == DEPTH);
        pv = e ? 2'b00 : m_stk[m_stk.size() - 1];
        mv = (m_mode == MReplay);
        mm = mv ? m_stk[m_rd] : 2'b00;
        xx = 4'(m_x);
        yy = 4'(m_y);
        return {e, f, pv, mv, mm, xx, yy, m_done, m_fail};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic cycle(input logic pu, po, input logic [1:0] v,
                         input logic so, ru, rdy, cl);
        push = pu; pop = po; push_val = v; solved = so; run = ru; move_ready = rdy; clr = cl;
        if (move_valid && rdy) acc.push_back(move);
        @(posedge clk);
        model_step(pu, po, v, so, ru, rdy, cl);
        #1;
        check("outputs", 32'(dut_vec), 32'(model_out()));
    endtask

    typedef struct {
        logic pu, po; logic [1:0] v; logic so, ru, rdy, cl;
        logic e; logic [1:0] pv; logic mv; logic [1:0] mm; logic [3:0] ex, ey; logic d;
    } vec_t;
    vec_t tbl[18];

    initial begin
        logic mv_seen;
        rst_n = 1'b0; clr = 0; push = 0; pop = 0; push_val = 0; solved = 0; run = 0;
        move_ready = 0;
        model_reset();
        #12;
        check("reset_vals", 32'(dut_vec), 32'h10000);
        @(negedge clk) rst_n = 1'b1;

        // pu po v so ru rdy cl | e pv mv mm x y done
        tbl[0]  = '{0,0,2'd0,0,0,0,1, 1,2'd0,0,2'd0,4'd0,4'd0,0};
        tbl[1]  = '{1,0,2'd1,0,0,0,0, 0,2'd1,0,2'd0,4'd0,4'd0,0};
        tbl[2]  = '{1,0,2'd1,0,0,0,0, 0,2'd1,0,2'd0,4'd0,4'd0,0};
        tbl[3]  = '{1,0,2'd3,0,0,0,0, 0,2'd3,0,2'd0,4'd0,4'd0,0};
        tbl[4]  = '{1,0,2'd3,0,0,0,0, 0,2'd3,0,2'd0,4'd0,4'd0,0};
        tbl[5]  = '{0,0,2'd0,1,0,0,0, 0,2'd3,0,2'd0,4'd0,4'd0,0};
        tbl[6]  = '{0,0,2'd0,0,1,1,0, 0,2'd3,1,2'd1,4'd0,4'd0,0};
        tbl[7]  = '{0,0,2'd0,0,0,1,0, 0,2'd3,1,2'd1,4'd1,4'd0,0};
        tbl[8]  = '{0,0,2'd0,0,0,1,0, 0,2'd3,1,2'd3,4'd2,4'd0,0};
        tbl[9]  = '{0,0,2'd0,0,0,1,0, 0,2'd3,1,2'd3,4'd2,4'd1,0};
        tbl[10] = '{0,0,2'd0,0,0,1,0, 0,2'd3,0,2'd0,4'd2,4'd2,1};
        tbl[11] = '{0,0,2'd0,0,1,1,0, 0,2'd3,0,2'd0,4'd2,4'd2,1};
        tbl[12] = '{0,0,2'd0,0,0,0,1, 1,2'd0,0,2'd0,4'd0,4'd0,0};
        tbl[13] = '{1,0,2'd1,0,0,0,0, 0,2'd1,0,2'd0,4'd0,4'd0,0};
        tbl[14] = '{1,0,2'd3,0,0,0,0, 0,2'd3,0,2'd0,4'd0,4'd0,0};
        tbl[15] = '{1,0,2'd2,0,0,0,0, 0,2'd2,0,2'd0,4'd0,4'd0,0};
        tbl[16] = '{0,1,2'd0,0,0,0,0, 0,2'd3,0,2'd0,4'd0,4'd0,0};
        tbl[17] = '{1,0,2'd3,0,0,0,0, 0,2'd3,0,2'd0,4'd0,4'd0,0};
        for (int i = 0; i < 18; i++) begin
            cycle(tbl[i].pu, tbl[i].po, tbl[i].v, tbl[i].so, tbl[i].ru, tbl[i].rdy, tbl[i].cl);
            check($sformatf("tbl_row%0d", i),
                  32'({empty, pop_val, move_valid, move, x, y, done}),
                  32'({tbl[i].e, tbl[i].pv, tbl[i].mv, tbl[i].mm, tbl[i].ex, tbl[i].ey, tbl[i].d}));
        end

        // Replay 01,11,11 with ready toggling 1,0,0,1.
        cycle(0, 0, 0, 1, 0, 0, 0);
        acc.delete();
        cycle(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 16; i++) cycle(0, 0, 0, 0, 0, (i % 4 == 0) || (i % 4 == 3), 0);
        check("toggle_count", acc.size(), 3);
        if (acc.size() == 3) check("toggle_seq", {acc[0], acc[1], acc[2]}, 6'b01_11_11);
        check("toggle_done", done, 1);

        // Underflow, ignored pushes while failed, then clear.
        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(0, 1, 0, 0, 0, 0, 0);
        check("underflow_fail", fail, 1);
        for (int i = 0; i < 3; i++) cycle(1, 0, 2'(i), 0, 0, 0, 0);
        check("err_push_ignored", empty, 1);
        cycle(0, 0, 0, 0, 0, 0, 1);
        check("clr_fail", {fail, empty}, 2'b01);

        // Fill to DEPTH, then overflow.
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 2'($urandom), 0, 0, 0, 0);
        check("full_after_depth", {full, fail}, 2'b10);
        cycle(1, 0, 0, 0, 0, 0, 0);
        check("overflow_fail", fail, 1);

        // Zero-move path.
        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, 0, 1, 0);
        mv_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 0, 1, 1, 0);
            mv_seen |= move_valid;
        end
        check("empty_run_done", {done, mv_seen}, 2'b10);

        // Wraparound: left from x=0, up from y=0.
        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(1, 0, 2'd2, 0, 0, 0, 0);
        cycle(1, 0, 2'd0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 1, 0);
        cycle(0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 1, 0);
        check("wrap_xy", {x, y, done}, {4'd15, 4'd15, 1'b1});

        // Asynchronous reset in the middle of a replay.
        cycle(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(1, 0, 2'd1, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 1, 0);
        cycle(0, 0, 0, 0, 0, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midreplay_reset", 32'(dut_vec), 32'h10000);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        cycle(0, 0, 0, 0, 0, 0, 0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(99) < 50, $urandom_range(99) < 20, 2'($urandom),
                  $urandom_range(99) < 6, $urandom_range(99) < 20,
                  $urandom_range(99) < 60, $urandom_range(99) < 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/maze_path_player.md
# maze_path_player

Path recorder and replay controller for the rat-in-maze solver. During search it serves as the solver's DFS move stack: push on advance, pop on backtrack. Once the solver signals a solution, the block locks the stack. On `run` it replays the recorded moves oldest-first to a downstream consumer over a valid/ready handshake, tracking the rat's coordinates and raising `done` after the last move.

## Interface
- `DEPTH`, 256, stack capacity in moves (power of two).
- `AW`, 8, pointer width, log2(DEPTH).
- `clk` in 1 clock, rising edge.
- `rst` in 1 asynchronous reset, active-low.
- `clr` in 1 synchronous clear to IDLE (empties stack, clears flags).
- `push` in 1 push `push_val` (IDLE only).
- `push_val` in 2 move to record.
- `pop` in 1 discard top entry (IDLE only).
- `pop_val` out 2 current top entry, combinational; 00 when empty.
- `empty` out 1 stack pointer == 0.
- `full` out 1 stack pointer == DEPTH.
- `solved` in 1 one-cycle pulse from solver: path complete.
- `run` in 1 start replay (READY only).
- `move_valid` out 1 `move` holds a replay move.
- `move_ready` in 1 consumer accepts move.
- `move` out 2 replayed move. Encoding: 00 up (y-1), 01 right (x+1), 10 left (x-1), 11 down (y+1).
- `x`, `y` out 4 each rat position.
- `done` out 1 replay finished, sticky.
- `fail` out 1 stack overflow or underflow, sticky.

## Operation
- States:
  - IDLE: stack accepts push/pop.
  - READY: stack locked, waiting for `run`.
  - REPLAY: moves streaming out.
  - DONE: replay complete.
  - ERR: stack misuse detected.
- IDLE:
  - `push` && !`full`: mem[sp] <= push_val, sp+1.
  - `pop` && !`empty`: sp-1.
  - `push` && `pop` && !`empty`: overwrite top, sp unchanged; `pop_val` shows old top that cycle.
  - `push` when `full`, or `pop` when `empty` (including simultaneous push+pop): go to ERR, `fail`=1, stack unchanged.
  - `solved`: go to READY. If `solved` coincides with push/pop, the stack op is applied first.
- READY:
  - `run` && sp!=0: rd pointer <= 0, x=y=0, go to REPLAY.
  - `run` && sp==0: go directly to DONE (zero-move path).
  - push/pop/solved ignored, no `fail`.
- REPLAY:
  - `move_valid`=1, `move`=mem[rd].
  - On valid&&ready: rd+1, x/y updated per encoding.
  - On the handshake with rd==sp-1: go to DONE.
  - `move`/`move_valid` stable while `move_ready`=0.
  - push/pop/solved/run ignored.
- DONE: `done`=1, `move_valid`=0. Stack contents retained; `run` ignored.
- ERR: `fail`=1, all inputs except `clr` ignored.
- `clr` (any state): sp=0, rd=0, x=y=0, done=fail=0, go to IDLE. `clr` overrides every other input the same cycle.
- Coordinate arithmetic is 4-bit modulo 16: x=0 with left gives 15; y=15 with down gives 0. Wall checking is the solver's responsibility.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE, sp=0, rd=0.
  - Outputs: `move_valid`=0, `move`=00, `x`=`y`=0, `done`=0, `fail`=0, `empty`=1, `full`=0, `pop_val`=00.
- Reset asserted mid-REPLAY aborts immediately. Stack contents are lost logically (sp=0).
- Push/pop take effect at the clock edge. `empty`, `full` and `pop_val` reflect the new sp in the following cycle.
- `solved` sampled at edge N: READY from N+1.
- `run` sampled at edge N: `move_valid`=1 from N+1 (registered).
- With `move_ready` held high, one move per cycle. An L-move replay spans L cycles of `move_valid`; `done` rises one cycle after the final handshake.
- `x`/`y` update at the handshake edge and are visible the next cycle.
- `done`/`fail` are registered and stay high until `clr` or reset.

## Test plan
- Push 01,01,11,11 then pulse `solved`, `run`, `move_ready`=1. Required: moves 01,01,11,11 on consecutive cycles; final x=2, y=2; `done` one cycle after the 4th handshake.
- Push 01,11,10; pop; push 11; replay. Required: sequence 01,11,11; `pop_val`=10 in the cycle before the pop edge.
- Replay with `move_ready` toggling 1,0,0,1,... Required: `move` held stable during low-ready cycles; no move skipped or duplicated.
- Pop on empty stack. Required: `fail`=1 next cycle, state ERR; later pushes ignored. Then `clr`. Required: `fail`=0, `empty`=1.
- DEPTH pushes then one more. Required: `full`=1 after the DEPTH-th push, `fail` on the extra push. Also `solved`+`run` on an empty stack: `done`=1 with `move_valid` never asserted.
- Left move from x=0: x=15. Reset deasserted-then-asserted mid-REPLAY: all outputs return to reset values immediately.
